// File: rtl/interconnect_cfg_sequencer.sv
// Config sequencer between the minion send stream and the address router: passes
// packets through, intercepts SEQ_ADDR commands, and replays a stored write script.
module interconnect_cfg_sequencer #(
  parameter int BIT_WIDTH = 32,
  parameter int ADDR_BITS = 4,
  parameter int N_ENTRIES = 8,
  parameter int SEQ_ADDR  = 15,
  parameter int DATA_BITS = 20
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           recv_val,
  output logic                           recv_rdy,
  input  logic [BIT_WIDTH+ADDR_BITS-1:0] recv_msg,
  output logic                           send_val,
  input  logic                           send_rdy,
  output logic [BIT_WIDTH+ADDR_BITS-1:0] send_msg,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(N_ENTRIES):0]     seq_len
);
  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int LEN_W = IDX_W + 1;
  localparam int MSG_W = BIT_WIDTH + ADDR_BITS;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  entry_t           ent [N_ENTRIES];
  entry_t           cur;
  logic [IDX_W-1:0] idx;
  logic             seq_hit, cmd_fire, last_fire;
  logic [1:0]       op;

  assign seq_hit   = recv_msg[MSG_W-1 -: ADDR_BITS] == ADDR_BITS'(SEQ_ADDR);
  assign op        = recv_msg[BIT_WIDTH-1 -: 2];
  assign cmd_fire  = reset && (state == IDLE) && seq_hit && recv_val;
  assign last_fire = (state == RUN) && send_rdy && ((LEN_W'(idx) + LEN_W'(1)) == seq_len);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    recv_rdy  = 1'b0;
    send_val  = 1'b0;
    send_msg  = recv_msg;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (seq_hit) begin
          recv_rdy = 1'b1;
          if (cmd_fire && op == 2'b11 && seq_len != '0) state_nxt = RUN;
        end else begin
          send_val = recv_val;
          recv_rdy = send_rdy;
        end
      end
      RUN: begin
        busy     = 1'b1;
        send_val = 1'b1;
        send_msg = {cur.addr, BIT_WIDTH'(cur.data)};
        if (last_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs must read idle the instant reset asserts, not at the next edge.
    if (!reset) begin
      recv_rdy = 1'b0;
      send_val = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ENTRIES; i++) ent[i] <= '0;
      seq_len <= '0;
      idx     <= '0;
      cur     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cmd_fire) begin
        case (op)
          2'b01: ent[recv_msg[27 +: IDX_W]] <= '{addr: recv_msg[DATA_BITS +: ADDR_BITS],
                                                data: recv_msg[DATA_BITS-1:0]};
          2'b10: begin
            if (int'(recv_msg[3:0]) > N_ENTRIES) seq_len <= LEN_W'(N_ENTRIES);
            else                                 seq_len <= LEN_W'(recv_msg[3:0]);
          end
          2'b11: begin
            if (seq_len == '0) done <= 1'b1;
            else begin
              idx <= '0;
              cur <= ent[0];
            end
          end
          default: ;
        endcase
      end
      // cur is the registered send_msg source; it only moves on a handshake.
      if (state == RUN && send_rdy) begin
        if (last_fire) done <= 1'b1;
        else begin
          idx <= idx + IDX_W'(1);
          cur <= ent[idx + IDX_W'(1)];
        end
      end
    end
  end
endmodule
